// File: rtl/edit_sequencer_pkg.sv
// Shared types for the clock edit sequencer.
// Cursor fields, repeat FSM states and button bundle.
package edit_sequencer_pkg;

  typedef enum logic [2:0] {
    CUR_RUN  = 3'd0,
    CUR_SEC  = 3'd1,
    CUR_MIN  = 3'd2,
    CUR_HOUR = 3'd3
  } cursor_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2
  } rep_e;

  typedef struct packed {
    logic rst;
    logic mode;
    logic dn;
    logic up;
  } btn_t;

  function automatic cursor_e cursor_next(
    input cursor_e c
  );
    case (c)
      CUR_RUN:  return CUR_HOUR;
      CUR_HOUR: return CUR_MIN;
      CUR_MIN:  return CUR_SEC;
      default:  return CUR_RUN;
    endcase
  endfunction

endpackage

// File: rtl/edit_sequencer_tick.sv
// Millisecond strobe generator.
// One-cycle pulse every CLK_HZ/1000 clocks.
module ms_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int W   = $clog2(DIV) + 1;

  logic [W-1:0] cnt;

  // Free-running divider, restarts from zero on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == W'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/edit_sequencer.sv
// Button-driven field editor for a clock display.
// Cursor, up/down auto-repeat, reset, timeout, blink.
module edit_sequencer
  import edit_sequencer_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int TIMEOUT_MS      = 10000,
  parameter int BLINK_MS        = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnMode,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnReset,
  output logic [2:0] cursorPos,
  output logic       up,
  output logic       down,
  output logic       reset,
  output logic       blink
);

  localparam int DW = $clog2(REPEAT_DELAY_MS) + 1;
  localparam int RW = $clog2(REPEAT_RATE_MS) + 1;
  localparam int TW = $clog2(TIMEOUT_MS) + 1;
  localparam int BW = $clog2(BLINK_MS) + 1;

  logic tick;

  ms_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  btn_t    lvl, prev, edg;
  cursor_e cur, cur_n;
  rep_e    state, state_n;

  logic dir, dir_n, fire;
  logic editing, active, both, held;
  logic do_rst, do_mode, do_to, cur_chg;
  logic quiet;

  logic [DW-1:0] dly_cnt;
  logic [DW-1:0] q_cnt;
  logic [RW-1:0] rate_cnt;
  logic [TW-1:0] ina_cnt;
  logic [BW-1:0] b_cnt;

  assign lvl = {btnReset, btnMode, btnDown, btnUp};
  assign edg = lvl & ~prev;

  assign editing = (cur != CUR_RUN);
  assign active  = |lvl;
  assign both    = btnUp & btnDown;
  assign held    = dir ? btnDown : btnUp;

  assign do_rst  = edg.rst && editing;
  assign do_mode = edg.mode && !do_rst;
  assign do_to   = editing && !active &&
                   (ina_cnt == TW'(TIMEOUT_MS));

  assign cursorPos = cur;

  // Cursor priority: reset edge, then mode edge, then timeout
  always_comb begin
    cur_n = cur;
    if (do_rst)
      cur_n = CUR_RUN;
    else if (do_mode)
      cur_n = cursor_next(cur);
    else if (do_to)
      cur_n = CUR_RUN;
    cur_chg = (cur_n != cur);
  end

  // Repeat FSM next state and pulse request
  always_comb begin
    state_n = state;
    dir_n   = dir;
    fire    = 1'b0;
    if (cur_chg || !editing || both) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (edg.up || edg.dn) begin
            state_n = PRESS;
            dir_n   = edg.dn;
            fire    = 1'b1;
          end
        end
        PRESS: begin
          if (!held)
            state_n = IDLE;
          else if (tick &&
                   dly_cnt == DW'(REPEAT_DELAY_MS - 1))
            state_n = REPEAT;
        end
        REPEAT: begin
          if (!held)
            state_n = IDLE;
          else if (tick &&
                   rate_cnt == RW'(REPEAT_RATE_MS - 1))
            fire = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Repeat FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dir   <= 1'b0;
    end else begin
      state <= state_n;
      dir   <= dir_n;
    end
  end

  // Hold-delay and repeat-rate timers live in their own state
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_cnt  <= '0;
      rate_cnt <= '0;
    end else begin
      if (state != PRESS || state_n != PRESS)
        dly_cnt <= '0;
      else if (tick && dly_cnt < DW'(REPEAT_DELAY_MS))
        dly_cnt <= dly_cnt + 1'b1;
      if (state != REPEAT || state_n != REPEAT || fire)
        rate_cnt <= '0;
      else if (tick && rate_cnt < RW'(REPEAT_RATE_MS))
        rate_cnt <= rate_cnt + 1'b1;
    end
  end

  // Edge history, cursor and registered command pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= lvl;
      cur   <= CUR_RUN;
      up    <= 1'b0;
      down  <= 1'b0;
      reset <= 1'b0;
    end else begin
      prev  <= lvl;
      cur   <= cur_n;
      up    <= fire && !dir_n;
      down  <= fire && dir_n;
      reset <= do_rst;
    end
  end

  // Inactivity timer, cleared by any held button
  always_ff @(posedge clk) begin
    if (rst || active || !editing)
      ina_cnt <= '0;
    else if (tick && ina_cnt < TW'(TIMEOUT_MS))
      ina_cnt <= ina_cnt + 1'b1;
  end

  // Blink toggling, suppressed after each up/down pulse
  always_ff @(posedge clk) begin
    if (rst || cur_n == CUR_RUN) begin
      blink <= 1'b0;
      b_cnt <= '0;
      quiet <= 1'b0;
      q_cnt <= '0;
    end else if (fire) begin
      blink <= 1'b0;
      b_cnt <= '0;
      quiet <= 1'b1;
      q_cnt <= '0;
    end else if (quiet) begin
      blink <= 1'b0;
      b_cnt <= '0;
      if (tick) begin
        if (q_cnt >= DW'(REPEAT_DELAY_MS - 1)) begin
          quiet <= 1'b0;
          q_cnt <= '0;
        end else begin
          q_cnt <= q_cnt + 1'b1;
        end
      end
    end else if (tick) begin
      if (b_cnt >= BW'(BLINK_MS - 1)) begin
        blink <= ~blink;
        b_cnt <= '0;
      end else begin
        b_cnt <= b_cnt + 1'b1;
      end
    end
  end

endmodule
